// File: rtl/i2c_slave_regwrite.sv
// I2C write responder: oversamples SCL/SDA on CLOCK, answers DEV_ADDR with an
// ACK and turns every data byte of [DEV_ADDR+W, SUB_ADDR, DATA...] into a
// one-cycle register-write strobe with auto-incrementing address.
module i2c_slave_regwrite #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic [7:0] REG_ADDR,
    output logic [7:0] REG_DATA,
    output logic       REG_WE,
    output logic       BUSY,
    output logic       ACK
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK, S_DATA, S_DATA_ACK, S_IGNORE
    } state_t;

    logic       scl_meta_q, scl_sync_q, scl_prev_q;
    logic       sda_meta_q, sda_sync_q, sda_prev_q;
    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_det, stop_det;
    logic [7:0] rx_byte;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_data_q, reg_data_d;
    logic       reg_we_q, reg_we_d;
    logic       ack_flag_q, ack_flag_d;
    logic       sda_drv_q, sda_drv_d;
    logic       wrote_q, wrote_d;

    // Bring the asynchronous bus lines into the CLOCK domain; idle level is 1
    // so reset must not fabricate an edge.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= I2C_SCLK;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= I2C_SDAT;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise  =  scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q &  scl_prev_q;
    assign sda_rise  =  sda_sync_q & ~sda_prev_q;
    assign sda_fall  = ~sda_sync_q &  sda_prev_q;
    assign start_det = sda_fall & scl_sync_q;
    assign stop_det  = sda_rise & scl_sync_q;
    assign rx_byte   = {shift_q[6:0], sda_sync_q};

    // State and datapath registers; reset also releases SDA at once.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            reg_we_q   <= 1'b0;
            ack_flag_q <= 1'b0;
            sda_drv_q  <= 1'b0;
            wrote_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            reg_we_q   <= reg_we_d;
            ack_flag_q <= ack_flag_d;
            sda_drv_q  <= sda_drv_d;
            wrote_q    <= wrote_d;
        end
    end

    // Next state: bus conditions override bit handling, so a partial byte is
    // simply dropped when START or STOP shows up.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        reg_we_d   = 1'b0;
        ack_flag_d = ack_flag_q;
        sda_drv_d  = sda_drv_q;
        wrote_d    = wrote_q;
        if (start_det) begin
            state_d    = S_ADDR;
            cnt_d      = '0;
            sda_drv_d  = 1'b0;
            ack_flag_d = 1'b0;
            wrote_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            sda_drv_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_SUB, S_DATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7 && state_q == S_SUB) begin
                            reg_addr_d = rx_byte;
                        end
                        if (cnt_q == 4'd7 && state_q == S_DATA) begin
                            reg_data_d = rx_byte;
                            reg_we_d   = 1'b1;
                            wrote_d    = 1'b1;
                            // Only bytes after the first move the address on.
                            if (wrote_q) begin
                                reg_addr_d = reg_addr_q + 8'd1;
                            end
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (state_q == S_ADDR) begin
                            cnt_d = '0;
                            if (shift_q[7:1] != DEV_ADDR) begin
                                state_d = S_IGNORE;
                            end else if (shift_q[0]) begin
                                state_d    = S_IGNORE;
                                ack_flag_d = 1'b1;
                            end else begin
                                state_d   = S_ADDR_ACK;
                                sda_drv_d = 1'b1;
                            end
                        end else begin
                            state_d   = (state_q == S_SUB) ? S_SUB_ACK : S_DATA_ACK;
                            sda_drv_d = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK, S_SUB_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_drv_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = (state_q == S_ADDR_ACK) ? S_SUB : S_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign I2C_SDAT = sda_drv_q ? 1'b0 : 1'bz;
    assign REG_ADDR = reg_addr_q;
    assign REG_DATA = reg_data_q;
    assign REG_WE   = reg_we_q;
    assign ACK      = ack_flag_q;
    assign BUSY     = (state_q inside {S_ADDR_ACK, S_SUB, S_SUB_ACK, S_DATA, S_DATA_ACK});

endmodule

// File: tb/tb_i2c_slave_regwrite.sv
// Directed bench for i2c_slave_regwrite: bit-banged I2C initiator with a
// pulled-up SDA line and a write-strobe logger.
module tb_i2c_slave_regwrite;

    localparam int Q = 8;   // quarter SCL period in CLOCK cycles (SCL = CLOCK/32)

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_low = 1'b0;
    wire  sda_bus;
    logic [7:0] reg_addr, reg_data;
    logic reg_we, busy, ackf;

    int total = 0;
    int bad = 0;
    int we_n = 0;
    int drv_n = 0;
    logic [7:0] we_addr [0:15];
    logic [7:0] we_data [0:15];

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    i2c_slave_regwrite #(.DEV_ADDR(7'h1A)) dut (
        .CLOCK   (clk),
        .RESET   (rst),
        .I2C_SCLK(scl),
        .I2C_SDAT(sda_bus),
        .REG_ADDR(reg_addr),
        .REG_DATA(reg_data),
        .REG_WE  (reg_we),
        .BUSY    (busy),
        .ACK     (ackf)
    );

    // Log every write strobe cycle and every cycle the DUT pulls SDA low.
    always @(negedge clk) begin
        if (reg_we) begin
            if (we_n < 16) begin
                we_addr[we_n] <= reg_addr;
                we_data[we_n] <= reg_data;
            end
            we_n <= we_n + 1;
        end
        if (!sda_low && sda_bus === 1'b0) drv_n <= drv_n + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_low = 1'b1; tick(Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic i2c_rstart();
        sda_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        sda_low = 1'b1; tick(Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            sda_low = ~b[i]; tick(Q);
            scl = 1'b1;      tick(2 * Q);
            scl = 1'b0;      tick(Q);
        end
        sda_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        acked = (sda_bus === 1'b0);
        tick(Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic i2c_stop(output logic b_before, output logic b_after);
        sda_low = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        sda_low = 1'b0;
        repeat (2) @(posedge clk);
        #1 b_before = busy;
        @(posedge clk);
        #1 b_after = busy;
        tick(Q);
    endtask

    task automatic test_reset();
        tick(5);
        rst = 1'b0;
        tick(5);
        total++; if (reg_addr !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h expected 00", reg_addr); end
        total++; if (reg_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", reg_data); end
        total++; if (reg_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b expected 0", reg_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (ackf !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b expected 0", ackf); end
        total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b expected 1", sda_bus); end
    endtask

    task automatic test_basic_write();
        int base;
        logic a0, a1, a2, bb, ba;
        base = we_n;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0A, a1);
        send_byte(8'h55, a2);
        total++; if (a0 !== 1'b1) begin bad++; $display("FAIL basic_ack_addr: got %b expected 1", a0); end
        total++; if (a1 !== 1'b1) begin bad++; $display("FAIL basic_ack_sub: got %b expected 1", a1); end
        total++; if (a2 !== 1'b1) begin bad++; $display("FAIL basic_ack_data: got %b expected 1", a2); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_mid: got %b expected 1", busy); end
        i2c_stop(bb, ba);
        total++; if (bb !== 1'b1) begin bad++; $display("FAIL basic_busy_stop2: got %b expected 1", bb); end
        total++; if (ba !== 1'b0) begin bad++; $display("FAIL basic_busy_stop3: got %b expected 0", ba); end
        total++; if (we_n - base !== 1) begin bad++; $display("FAIL basic_we_count: got %0d expected 1", we_n - base); end
        if (we_n - base >= 1) begin
            total++; if (we_addr[base] !== 8'h0A) begin bad++; $display("FAIL basic_we_addr: got %h expected 0a", we_addr[base]); end
            total++; if (we_data[base] !== 8'h55) begin bad++; $display("FAIL basic_we_data: got %h expected 55", we_data[base]); end
        end
    endtask

    task automatic test_other_addr();
        int base, dbase;
        logic a0, a1, a2, bb, ba;
        base = we_n;
        dbase = drv_n;
        i2c_start();
        send_byte(8'h36, a0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL other_busy: got %b expected 0", busy); end
        send_byte(8'h0A, a1);
        send_byte(8'h55, a2);
        i2c_stop(bb, ba);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL other_acks: got %b expected 000", {a0, a1, a2}); end
        total++; if (drv_n - dbase !== 0) begin bad++; $display("FAIL other_sda_driven: got %0d cycles expected 0", drv_n - dbase); end
        total++; if (we_n - base !== 0) begin bad++; $display("FAIL other_we_count: got %0d expected 0", we_n - base); end
        total++; if (ackf !== 1'b0) begin bad++; $display("FAIL other_ack_flag: got %b expected 0", ackf); end
    endtask

    task automatic test_read_nack();
        logic a0, a1, bb, ba;
        i2c_start();
        send_byte(8'h35, a0);
        total++; if (a0 !== 1'b0) begin bad++; $display("FAIL read_slot9: got %b expected 0", a0); end
        total++; if (ackf !== 1'b1) begin bad++; $display("FAIL read_ack_flag: got %b expected 1", ackf); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy: got %b expected 0", busy); end
        i2c_rstart();
        total++; if (ackf !== 1'b0) begin bad++; $display("FAIL read_ack_clear: got %b expected 0", ackf); end
        send_byte(8'h34, a1);
        total++; if (a1 !== 1'b1) begin bad++; $display("FAIL read_then_write_ack: got %b expected 1", a1); end
        i2c_stop(bb, ba);
    endtask

    task automatic test_autoinc();
        int base;
        logic a, bb, ba;
        logic [7:0] ea [0:2];
        logic [7:0] ed [0:2];
        ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
        ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33;
        base = we_n;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'hFE, a);
        send_byte(8'h11, a);
        send_byte(8'h22, a);
        send_byte(8'h33, a);
        i2c_stop(bb, ba);
        total++; if (we_n - base !== 3) begin bad++; $display("FAIL autoinc_count: got %0d expected 3", we_n - base); end
        for (int k = 0; k < 3; k++) begin
            if (we_n - base > k) begin
                total++; if (we_addr[base + k] !== ea[k]) begin bad++; $display("FAIL autoinc_addr%0d: got %h expected %h", k, we_addr[base + k], ea[k]); end
                total++; if (we_data[base + k] !== ed[k]) begin bad++; $display("FAIL autoinc_data%0d: got %h expected %h", k, we_data[base + k], ed[k]); end
            end
        end
    endtask

    task automatic test_back_to_back_rstart();
        int base;
        logic a, bb, ba;
        base = we_n;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h20, a);
        i2c_rstart();
        send_byte(8'h34, a);
        send_byte(8'h21, a);
        send_byte(8'h77, a);
        i2c_stop(bb, ba);
        total++; if (we_n - base !== 1) begin bad++; $display("FAIL rstart_count: got %0d expected 1", we_n - base); end
        if (we_n - base >= 1) begin
            total++; if (we_addr[base] !== 8'h21) begin bad++; $display("FAIL rstart_addr: got %h expected 21", we_addr[base]); end
            total++; if (we_data[base] !== 8'h77) begin bad++; $display("FAIL rstart_data: got %h expected 77", we_data[base]); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        logic a, bb, ba;
        logic [7:0] b;
        b = 8'hAD;
        base = we_n;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h10, a);
        for (int i = 7; i >= 4; i--) begin
            sda_low = ~b[i]; tick(Q);
            scl = 1'b1;      tick(2 * Q);
            scl = 1'b0;      tick(Q);
        end
        sda_low = ~b[3]; tick(Q);
        scl = 1'b1;      tick(Q);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL mid_sda: got %b expected 1", sda_bus); end
        total++; if (reg_addr !== 8'h00) begin bad++; $display("FAIL mid_addr: got %h expected 00", reg_addr); end
        total++; if (reg_data !== 8'h00) begin bad++; $display("FAIL mid_data: got %h expected 00", reg_data); end
        total++; if (reg_we !== 1'b0) begin bad++; $display("FAIL mid_we: got %b expected 0", reg_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
        total++; if (ackf !== 1'b0) begin bad++; $display("FAIL mid_ack: got %b expected 0", ackf); end
        scl = 1'b0;     tick(Q);
        sda_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        rst = 1'b0;     tick(Q);
        total++; if (we_n - base !== 0) begin bad++; $display("FAIL mid_no_we: got %0d expected 0", we_n - base); end
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h42, a);
        send_byte(8'h99, a);
        i2c_stop(bb, ba);
        total++; if (we_n - base !== 1) begin bad++; $display("FAIL mid_after_count: got %0d expected 1", we_n - base); end
        if (we_n - base >= 1) begin
            total++; if (we_addr[base] !== 8'h42) begin bad++; $display("FAIL mid_after_addr: got %h expected 42", we_addr[base]); end
            total++; if (we_data[base] !== 8'h99) begin bad++; $display("FAIL mid_after_data: got %h expected 99", we_data[base]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_other_addr();
        test_read_nack();
        test_autoinc();
        test_back_to_back_rstart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
